// File: rtl/cpu_sram_responder.sv
// Memory-side responder for the CPU instruction and data SRAM-style ports.
// One unified word-addressed memory serves a read-only instruction port and a
// byte-enabled read/write data port. Data accesses inside the MMIO window are
// routed to a small register file (LED, switches, timer, scratch).
//
// Request/response protocol (both ports): a request is a cycle with en=1
// sampled at a rising edge; there is no ready/stall, every request is accepted.
// Its read data appears on rdata after that edge and stays valid for the whole
// following cycle. With en=0 rdata holds. Writes return the pre-write word.
module cpu_sram_responder #(
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000,
    parameter logic [31:0] MMIO_MASK = 32'hffff_0000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    input  logic [15:0] switch,
    output logic [15:0] led
);

    localparam int DEPTH = 1 << MEM_AW;

    localparam logic [13:0] OFF_LED     = 14'd0;
    localparam logic [13:0] OFF_SWITCH  = 14'd1;
    localparam logic [13:0] OFF_TIMER   = 14'd2;
    localparam logic [13:0] OFF_SCRATCH = 14'd3;

    // Byte-wise merge of new data into an old word under byte enables.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem [DEPTH];

    logic [MEM_AW-1:0] inst_idx;
    logic [MEM_AW-1:0] data_idx;
    logic [13:0]       mmio_off;
    logic              data_is_mmio;
    logic              data_wr;
    logic              mem_wr;
    logic              mmio_wr;

    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic [15:0] led_q;
    logic [31:0] timer_q;
    logic [31:0] scratch_q;

    logic [15:0] led_next;
    logic [31:0] mmio_word;

    logic [31:0] inst_rdata_q;
    logic [31:0] data_mem_q;
    logic [31:0] data_mmio_q;
    logic        last_mmio_q;

    // Inputs that carry no meaning for this responder.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_we, inst_sram_wdata,
                             inst_sram_addr[31:MEM_AW+2], inst_sram_addr[1:0]};

    // Address decode; byte offset bits and bits above the memory index are ignored.
    assign inst_idx     = inst_sram_addr[MEM_AW+1:2];
    assign data_idx     = data_sram_addr[MEM_AW+1:2];
    assign mmio_off     = data_sram_addr[15:2];
    assign data_is_mmio = (data_sram_addr & MMIO_MASK) == MMIO_BASE;

    // Writes are suppressed entirely while reset is high.
    assign data_wr = data_sram_en && (data_sram_we != 4'b0000) && !reset;
    assign mem_wr  = data_wr && !data_is_mmio;
    assign mmio_wr = data_wr && data_is_mmio;

    // LED holds only 16 bits, so only byte enables 0 and 1 apply.
    assign led_next = {data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8],
                       data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0]};

    // MMIO read word from the current register values (read-first).
    always_comb begin
        mmio_word = 32'h0;
        case (mmio_off)
            OFF_LED:     mmio_word = {16'h0, led_q};
            OFF_SWITCH:  mmio_word = {16'h0, sw_sync};
            OFF_TIMER:   mmio_word = timer_q;
            OFF_SCRATCH: mmio_word = scratch_q;
            default:     mmio_word = 32'h0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    // MMIO registers; the timer free-runs except in a cycle that writes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= 16'h0;
            timer_q   <= 32'h0;
            scratch_q <= 32'h0;
        end else begin
            if (mmio_wr && mmio_off == OFF_LED) begin
                led_q <= led_next;
            end
            if (mmio_wr && mmio_off == OFF_TIMER) begin
                timer_q <= merge_bytes(timer_q, data_sram_wdata, data_sram_we);
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            if (mmio_wr && mmio_off == OFF_SCRATCH) begin
                scratch_q <= merge_bytes(scratch_q, data_sram_wdata, data_sram_we);
            end
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read registers: sample the old word on the request edge, hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_rdata_q <= 32'h0;
            data_mem_q   <= 32'h0;
            data_mmio_q  <= 32'h0;
            last_mmio_q  <= 1'b0;
        end else begin
            if (inst_sram_en) begin
                inst_rdata_q <= mem[inst_idx];
            end
            if (data_sram_en) begin
                last_mmio_q <= data_is_mmio;
                if (data_is_mmio) begin
                    data_mmio_q <= mmio_word;
                end else begin
                    data_mem_q <= mem[data_idx];
                end
            end
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = last_mmio_q ? data_mmio_q : data_mem_q;
    assign led             = led_q;

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Directed bench for cpu_sram_responder: a driver issues one request per cycle
// and queues the expected response; a monitor pops and compares each response.
module tb_cpu_sram_responder;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] switch;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;

    logic [31:0] d_exp_q[$];
    bit          d_care_q[$];
    logic [31:0] i_exp_q[$];

    localparam logic [31:0] LED_A  = 32'hbfaf_0000;
    localparam logic [31:0] SW_A   = 32'hbfaf_0004;
    localparam logic [31:0] TMR_A  = 32'hbfaf_0008;
    localparam logic [31:0] SCR_A  = 32'hbfaf_000c;
    localparam logic [31:0] BAD_A  = 32'hbfaf_0040;

    cpu_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One cycle of stimulus, driven on the falling edge; queue expected responses.
    task automatic cyc(input logic rst,
                       input logic i_en, input logic [31:0] i_addr, input logic [31:0] i_exp,
                       input logic d_en, input logic [3:0] d_we, input logic [31:0] d_addr,
                       input logic [31:0] d_wdata, input logic [31:0] d_exp, input bit d_care);
        @(negedge clk);
        reset           = rst;
        inst_sram_en    = i_en;
        inst_sram_addr  = i_addr;
        inst_sram_we    = 4'hf;
        inst_sram_wdata = 32'hdead_beef;
        data_sram_en    = d_en;
        data_sram_we    = d_we;
        data_sram_addr  = d_addr;
        data_sram_wdata = d_wdata;
        if (i_en && !rst) i_exp_q.push_back(i_exp);
        if (d_en && !rst) begin
            d_exp_q.push_back(d_exp);
            d_care_q.push_back(d_care);
        end
    endtask

    task automatic drd(input logic [31:0] addr, input logic [31:0] exp);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'h0, addr, 32'h0, exp, 1'b1);
    endtask

    task automatic dwr(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input bit care);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, we, addr, wdata, exp, care);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: a request accepted at a rising edge is checked at the next falling edge.
    initial begin
        logic dv, iv;
        logic [31:0] e;
        bit c;
        forever begin
            @(posedge clk);
            dv = data_sram_en && !reset;
            iv = inst_sram_en && !reset;
            @(negedge clk);
            if (dv) begin
                if (d_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_unexpected: got %h expected no response", data_sram_rdata);
                end else begin
                    e = d_exp_q.pop_front();
                    c = d_care_q.pop_front();
                    if (c) chk("data_rdata", data_sram_rdata, e);
                end
            end
            if (iv) begin
                if (i_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected: got %h expected no response", inst_sram_rdata);
                end else begin
                    e = i_exp_q.pop_front();
                    chk("inst_rdata", inst_sram_rdata, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        inst_sram_en = 1'b0; inst_sram_we = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        data_sram_en = 1'b0; data_sram_we = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        switch = 16'h0;

        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("reset_data_rdata", data_sram_rdata, 32'h0);
        chk("reset_inst_rdata", inst_sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);

        // Preload; old contents are unknown so those responses are not compared.
        dwr(4'hf, 32'h40, 32'h1234_5678, 32'h0, 1'b0);
        dwr(4'hf, 32'h80, 32'h0000_0000, 32'h0, 1'b0);

        // Basic reads on both ports
        cyc(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b1, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b1);

        // Partial write returns the old word, then the merged word holds
        dwr(4'b0101, 32'h40, 32'haabb_ccdd, 32'h1234_5678, 1'b1);
        drd(32'h40, 32'h12bb_56dd);
        drd(32'h40, 32'h12bb_56dd);
        idle(2);
        chk("idle_hold", data_sram_rdata, 32'h12bb_56dd);

        // Upper address bits and byte offset are ignored
        drd(32'h0004_0040, 32'h12bb_56dd);
        drd(32'h0000_0043, 32'h12bb_56dd);

        // Collision: instruction read sees the old word, next read the new one
        cyc(1'b0, 1'b1, 32'h80, 32'h0, 1'b1, 4'hf, 32'h80, 32'hffff_ffff, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h80, 32'hffff_ffff, 1'b1, 4'h0, 32'h80, 32'h0, 32'hffff_ffff, 1'b1);

        // LED
        dwr(4'hf, LED_A, 32'h0000_a5a5, 32'h0, 1'b1);
        idle(1);
        chk("led_write", {16'h0, led}, 32'h0000_a5a5);
        drd(LED_A, 32'h0000_a5a5);
        dwr(4'b0001, LED_A, 32'hffff_ff00, 32'h0000_a5a5, 1'b1);
        drd(LED_A, 32'h0000_a500);
        dwr(4'b1100, LED_A, 32'hffff_ffff, 32'h0000_a500, 1'b1);
        drd(LED_A, 32'h0000_a500);

        // Switches through the synchronizer; writes ignored
        switch = 16'h3c3c;
        idle(3);
        drd(SW_A, 32'h0000_3c3c);
        dwr(4'hf, SW_A, 32'h0000_ffff, 32'h0000_3c3c, 1'b1);
        drd(SW_A, 32'h0000_3c3c);

        // Unmapped MMIO offset
        drd(BAD_A, 32'h0);
        dwr(4'hf, BAD_A, 32'h1234_5678, 32'h0, 1'b1);
        drd(BAD_A, 32'h0);

        // Timer: load does not increment, reads return the value at the edge, wrap
        dwr(4'hf, TMR_A, 32'hffff_fffe, 32'h0, 1'b0);
        drd(TMR_A, 32'hffff_fffe);
        drd(TMR_A, 32'hffff_ffff);
        drd(TMR_A, 32'h0000_0000);
        dwr(4'hf, TMR_A, 32'ha1b2_c3d4, 32'h0000_0001, 1'b1);
        drd(TMR_A, 32'ha1b2_c3d4);
        dwr(4'b0001, TMR_A, 32'h0000_0055, 32'ha1b2_c3d5, 1'b1);
        drd(TMR_A, 32'ha1b2_c355);

        // Scratch with byte enables
        dwr(4'hf, SCR_A, 32'h1122_3344, 32'h0, 1'b1);
        dwr(4'b1010, SCR_A, 32'haabb_ccdd, 32'h1122_3344, 1'b1);
        drd(SCR_A, 32'haa22_cc44);

        // Reset mid-stream with a pending read and a write under reset
        dwr(4'hf, LED_A, 32'h0000_ffff, 32'h0000_a500, 1'b1);
        dwr(4'hf, 32'h40, 32'h1234_5678, 32'h12bb_56dd, 1'b1);
        idle(1);
        chk("led_ffff", {16'h0, led}, 32'h0000_ffff);
        cyc(1'b1, 1'b1, 32'h40, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 4'hf, 32'h40, 32'hdead_beef, 32'h0, 1'b0);
        @(negedge clk);
        chk("midreset_data_rdata", data_sram_rdata, 32'h0);
        chk("midreset_inst_rdata", inst_sram_rdata, 32'h0);
        chk("midreset_led", {16'h0, led}, 32'h0);
        drd(TMR_A, 32'h0);
        cyc(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b1, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b1);
        drd(SCR_A, 32'h0);
        idle(3);

        checks++;
        if (d_exp_q.size() != 0 || i_exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d data %0d inst left expected 0",
                     d_exp_q.size(), i_exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
